// File: rtl/wb_select_stage.sv
// Writeback-select stage: picks immediate, ALU result or load data for regD
// and drives a one-cycle register-file write strobe.
module wb_select_stage #(
    parameter int             DATA_W       = 16,
    parameter int             OPC_W        = 4,
    parameter int             RADDR_W      = 4,
    parameter logic [OPC_W-1:0] LOAD_OP    = 4'b1100,
    parameter bit             R0_HARDWIRED = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic [DATA_W-1:0]  imm_out,
    input  logic               imm_en,
    input  logic [OPC_W-1:0]   op_code,
    input  logic [RADDR_W-1:0] rd_addr,
    input  logic [1:0]         ld_mode,
    input  logic               flush,
    input  logic               mem_rvalid,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               wb_en,
    output logic [RADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    output logic               busy
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [RADDR_W-1:0]   r_ld_addr;
    logic [1:0]           r_ld_mode;
    logic                 r_wb_en;
    logic [RADDR_W-1:0]   r_wb_addr;
    logic [DATA_W-1:0]    r_wb_data;

    logic                 w_accept;
    logic                 w_is_load;
    logic                 w_upd;
    logic [RADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]    w_data;
    logic [DATA_W-1:0]    w_fmt;
    logic                 w_wr_ok;

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == WAIT_MEM);
    assign wb_en     = r_wb_en;
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_wb_data;

    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_is_load = ~imm_en & (op_code == LOAD_OP);
    assign w_wr_ok   = ~(R0_HARDWIRED && (w_addr == '0));

    // Byte modes rewrite only the upper bits; mode 11 behaves as full word.
    always_comb begin
        w_fmt = mem_rdata;
        for (int i = 8; i < DATA_W; i++) begin
            if (r_ld_mode == 2'b01) begin
                w_fmt[i] = 1'b0;
            end else if (r_ld_mode == 2'b10) begin
                w_fmt[i] = mem_rdata[7];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_upd       = 1'b0;
        w_addr      = r_wb_addr;
        w_data      = r_wb_data;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_load) begin
                        w_state_nxt = WAIT_MEM;
                    end else begin
                        w_upd  = 1'b1;
                        w_addr = rd_addr;
                        w_data = imm_en ? imm_out : alu_out;
                    end
                end
            end
            WAIT_MEM: begin
                // Flush wins over a same-cycle memory response.
                if (flush) begin
                    w_state_nxt = IDLE;
                end else if (mem_rvalid) begin
                    w_upd       = 1'b1;
                    w_addr      = r_ld_addr;
                    w_data      = w_fmt;
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ld_addr <= '0;
            r_ld_mode <= '0;
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wb_en <= w_upd & w_wr_ok;
            if (w_upd) begin
                r_wb_addr <= w_addr;
                r_wb_data <= w_data;
            end
            if (w_accept && w_is_load) begin
                r_ld_addr <= rd_addr;
                r_ld_mode <= ld_mode;
            end
        end
    end

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed testbench for wb_select_stage with immediate-assertion checks.
module tb_wb_select_stage;

    localparam int DW = 16;
    localparam int OW = 4;
    localparam int AW = 4;
    localparam logic [3:0] LD = 4'b1100;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] imm_out;
    logic          imm_en;
    logic [OW-1:0] op_code;
    logic [AW-1:0] rd_addr;
    logic [1:0]    ld_mode;
    logic          flush;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    wb_select_stage #(
        .DATA_W(DW), .OPC_W(OW), .RADDR_W(AW),
        .LOAD_OP(LD), .R0_HARDWIRED(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .imm_out(imm_out), .imm_en(imm_en),
        .op_code(op_code), .rd_addr(rd_addr), .ld_mode(ld_mode),
        .flush(flush), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic en,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk({tag, ".en"}, {31'd0, wb_en}, {31'd0, en});
        chk({tag, ".addr"}, {28'd0, wb_addr}, {28'd0, a});
        chk({tag, ".data"}, {16'd0, wb_data}, {16'd0, d});
    endtask

    task automatic chk_st(input string tag, input logic rdy, input logic bsy);
        chk({tag, ".rdy"}, {31'd0, in_ready}, {31'd0, rdy});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bsy});
    endtask

    task automatic drive(input logic v, input logic ie, input logic [3:0] op,
                         input logic [15:0] imm, input logic [15:0] alu,
                         input logic [3:0] rd, input logic [1:0] md);
        in_valid = v;
        imm_en   = ie;
        op_code  = op;
        imm_out  = imm;
        alu_out  = alu;
        rd_addr  = rd;
        ld_mode  = md;
    endtask

    task automatic load(input string tag, input logic [3:0] rd,
                        input logic [1:0] md, input logic [15:0] rdata,
                        input logic [15:0] exp);
        drive(1, 0, LD, 16'h0, 16'h0, rd, md);
        tick();
        chk_st({tag, ".acc"}, 0, 1);
        drive(0, 0, 4'h0, 16'h0, 16'h0, 4'h0, 2'b00);
        mem_rvalid = 1;
        mem_rdata  = rdata;
        tick();
        chk_wb(tag, 1, rd, exp);
        chk_st({tag, ".done"}, 1, 0);
        mem_rvalid = 0;
    endtask

    initial begin
        rst_n      = 0;
        flush      = 0;
        mem_rvalid = 0;
        mem_rdata  = '0;
        drive(0, 0, 4'h0, 16'h0, 16'h0, 4'h0, 2'b00);
        tick();
        tick();
        chk_wb("reset", 0, 4'h0, 16'h0000);
        chk_st("reset", 1, 0);
        rst_n = 1;

        // back-to-back non-loads, imm_en beats LOAD_OP
        drive(1, 1, 4'h0, 16'h1234, 16'h0, 4'h1, 2'b00);
        tick();
        chk_wb("b2b1", 1, 4'h1, 16'h1234);
        drive(1, 0, 4'h2, 16'h0, 16'hBEEF, 4'h2, 2'b00);
        tick();
        chk_wb("b2b2", 1, 4'h2, 16'hBEEF);
        drive(1, 1, LD, 16'h0042, 16'h0, 4'h4, 2'b00);
        tick();
        chk_wb("b2b3", 1, 4'h4, 16'h0042);
        chk_st("b2b3", 1, 0);
        drive(0, 0, 4'h0, 16'h0, 16'h0, 4'h0, 2'b00);
        tick();
        chk_wb("b2bidle", 0, 4'h4, 16'h0042);

        // reset while a load is outstanding
        drive(1, 0, LD, 16'h0, 16'h0, 4'h3, 2'b00);
        tick();
        chk_st("rstld.acc", 0, 1);
        drive(0, 0, 4'h0, 16'h0, 16'h0, 4'h0, 2'b00);
        rst_n = 0;
        #1;
        chk_wb("rstld", 0, 4'h0, 16'h0000);
        chk_st("rstld", 1, 0);
        tick();
        rst_n      = 1;
        mem_rvalid = 1;
        mem_rdata  = 16'h5555;
        tick();
        chk_wb("rstld.late", 0, 4'h0, 16'h0000);
        mem_rvalid = 0;

        // load with 3-cycle memory latency, in_valid ignored while waiting
        drive(1, 0, LD, 16'h0, 16'h0, 4'h5, 2'b10);
        tick();
        chk_st("lat.w1", 0, 1);
        chk_wb("lat.w1", 0, 4'h0, 16'h0000);
        drive(1, 0, 4'h2, 16'h0, 16'h1111, 4'h7, 2'b00);
        tick();
        chk_st("lat.w2", 0, 1);
        chk_wb("lat.w2", 0, 4'h0, 16'h0000);
        tick();
        chk_st("lat.w3", 0, 1);
        chk_wb("lat.w3", 0, 4'h0, 16'h0000);
        drive(0, 0, 4'h0, 16'h0, 16'h0, 4'h0, 2'b00);
        mem_rvalid = 1;
        mem_rdata  = 16'h0080;
        tick();
        chk_wb("lat.wr", 1, 4'h5, 16'hFF80);
        chk_st("lat.wr", 1, 0);
        mem_rvalid = 0;
        tick();
        chk_wb("lat.once", 0, 4'h5, 16'hFF80);

        // load formatting modes
        load("zext", 4'h6, 2'b01, 16'hAB80, 16'h0080);
        load("full00", 4'h8, 2'b00, 16'hAB80, 16'hAB80);
        load("full11", 4'h9, 2'b11, 16'hAB80, 16'hAB80);

        // next instruction directly after the load write, no gap
        drive(1, 0, 4'h2, 16'h0, 16'h5A5A, 4'hA, 2'b00);
        tick();
        chk_wb("nogap", 1, 4'hA, 16'h5A5A);

        // flush beats mem_rvalid in WAIT_MEM
        drive(1, 0, LD, 16'h0, 16'h0, 4'hB, 2'b00);
        tick();
        chk_st("fl.acc", 0, 1);
        drive(0, 0, 4'h0, 16'h0, 16'h0, 4'h0, 2'b00);
        flush      = 1;
        mem_rvalid = 1;
        mem_rdata  = 16'h1234;
        tick();
        chk_wb("fl.wait", 0, 4'hA, 16'h5A5A);
        chk_st("fl.wait", 1, 0);
        mem_rvalid = 0;

        // flush in IDLE blocks both non-load and load acceptance
        drive(1, 0, 4'h2, 16'h0, 16'h7777, 4'hC, 2'b00);
        tick();
        chk_wb("fl.idle", 0, 4'hA, 16'h5A5A);
        chk_st("fl.idle", 1, 0);
        drive(1, 0, LD, 16'h0, 16'h0, 4'hC, 2'b00);
        tick();
        chk_st("fl.idleld", 1, 0);
        chk_wb("fl.idleld", 0, 4'hA, 16'h5A5A);
        flush = 0;

        // writes to r0 suppressed, data/addr still update
        drive(1, 0, 4'h2, 16'h0, 16'h1357, 4'h0, 2'b00);
        tick();
        chk_wb("r0alu", 0, 4'h0, 16'h1357);
        drive(1, 0, LD, 16'h0, 16'h0, 4'h0, 2'b10);
        tick();
        chk_st("r0ld.acc", 0, 1);
        drive(0, 0, 4'h0, 16'h0, 16'h0, 4'h0, 2'b00);
        tick();
        chk_st("r0ld.hold", 0, 1);
        chk_wb("r0ld.hold", 0, 4'h0, 16'h1357);
        mem_rvalid = 1;
        mem_rdata  = 16'h00FF;
        tick();
        chk_wb("r0ld", 0, 4'h0, 16'hFFFF);
        chk_st("r0ld", 1, 0);
        mem_rvalid = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
